// File: rtl/iob_clint_timer_agent_if.sv
// IOb native bus between the CLINT timer agent (master) and the CLINT (slave).
//   iob_avalid / iob_addr / iob_wdata / iob_wstrb : request, driven by master
//   iob_ready                                     : request accepted, driven by slave
//   iob_rvalid / iob_rdata                        : read response, driven by slave
interface iob_clint_timer_agent_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                iob_avalid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic                iob_rvalid;
  logic [DATA_W-1:0]   iob_rdata;
  logic                iob_ready;

  modport master (
    output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rvalid, iob_rdata, iob_ready
  );

  modport slave (
    input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rvalid, iob_rdata, iob_ready
  );
endinterface

// File: rtl/iob_clint_timer_agent.sv
// CLINT timer agent: IOb initiator serving a local command/response port.
//   Commands: 0 RD_TIME     coherent 64-bit mtime read (hi, lo, hi with retry)
//             1 SET_CMP_ABS program mtimecmp[hart] with cmd_data_i
//             2 SET_CMP_REL program mtimecmp[hart] with mtime + cmd_data_i
//             3 SET_MSIP    write cmd_data_i[0] to msip[hart]
// Ports:
//   clk_i, arst_i (async, active-high), cke_i (0 freezes all state)
//   cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_hart_i/cmd_data_i : command request
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o           : response
//   iob (master modport)                                   : IOb bus to the CLINT
module iob_clint_timer_agent #(
  parameter int                N_CORES   = 1,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_RETRY = 3,
  parameter int                HART_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       cke_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [HART_W-1:0]          cmd_hart_i,
  input  logic [63:0]                cmd_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [63:0]                rsp_data_o,
  output logic                       rsp_err_o,
  iob_clint_timer_agent_if.master    iob
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RD_HI1  = 4'd1;
  localparam logic [3:0] ST_RD_LO   = 4'd2;
  localparam logic [3:0] ST_RD_HI2  = 4'd3;
  localparam logic [3:0] ST_ADD     = 4'd4;
  localparam logic [3:0] ST_WR_LO1  = 4'd5;
  localparam logic [3:0] ST_WR_HI   = 4'd6;
  localparam logic [3:0] ST_WR_LO2  = 4'd7;
  localparam logic [3:0] ST_WR_MSIP = 4'd8;
  localparam logic [3:0] ST_RESP    = 4'd9;

  localparam logic [1:0] OP_RD_TIME     = 2'd0;
  localparam logic [1:0] OP_SET_CMP_ABS = 2'd1;
  localparam logic [1:0] OP_SET_CMP_REL = 2'd2;
  localparam logic [1:0] OP_SET_MSIP    = 2'd3;

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_W-1:0] OFF_MTIMECMP = ADDR_W'(32'h4000);
  localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'(32'hBFFC);

  logic [3:0]         state_q;
  logic [1:0]         op_q;
  logic [HART_W-1:0]  hart_q;
  logic [63:0]        target_q;   // abs target, delta, then computed target
  logic [DATA_W-1:0]  hi1_q;
  logic [DATA_W-1:0]  lo_q;
  logic [RETRY_W-1:0] retry_q;
  logic               rd_wait_q;  // read accepted, waiting for rvalid

  logic               hart_ok;
  logic [ADDR_W-1:0]  hart_off;
  logic [ADDR_W-1:0]  cmp_lo_addr;
  logic               rd_accept;
  logic               rd_done;

  assign hart_ok     = 32'(cmd_hart_i) < 32'(N_CORES);
  assign hart_off    = ADDR_W'(hart_q);
  assign cmp_lo_addr = BASE_ADDR + OFF_MTIMECMP + (hart_off << 3);

  // rvalid is only honoured once the read has been accepted, so a stray
  // rvalid in the acceptance cycle or while no read is pending is ignored.
  assign rd_accept = !rd_wait_q && iob.iob_ready;
  assign rd_done   = rd_wait_q && iob.iob_rvalid;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);

  always_comb begin
    iob.iob_avalid = 1'b0;
    iob.iob_addr   = '0;
    iob.iob_wdata  = '0;
    iob.iob_wstrb  = '0;
    case (state_q)
      ST_RD_HI1, ST_RD_HI2: begin
        iob.iob_avalid = !rd_wait_q;
        iob.iob_addr   = BASE_ADDR + OFF_MTIME_HI;
      end
      ST_RD_LO: begin
        iob.iob_avalid = !rd_wait_q;
        iob.iob_addr   = BASE_ADDR + OFF_MTIME_LO;
      end
      // lo is parked at all-ones first so no intermediate {new_hi, old_lo}
      // value can fall below mtime and raise a spurious mtip.
      ST_WR_LO1: begin
        iob.iob_avalid = 1'b1;
        iob.iob_addr   = cmp_lo_addr;
        iob.iob_wdata  = '1;
        iob.iob_wstrb  = '1;
      end
      ST_WR_HI: begin
        iob.iob_avalid = 1'b1;
        iob.iob_addr   = cmp_lo_addr + ADDR_W'(32'd4);
        iob.iob_wdata  = target_q[63:32];
        iob.iob_wstrb  = '1;
      end
      ST_WR_LO2: begin
        iob.iob_avalid = 1'b1;
        iob.iob_addr   = cmp_lo_addr;
        iob.iob_wdata  = target_q[31:0];
        iob.iob_wstrb  = '1;
      end
      ST_WR_MSIP: begin
        iob.iob_avalid = 1'b1;
        iob.iob_addr   = BASE_ADDR + (hart_off << 2);
        iob.iob_wdata  = {{(DATA_W-1){1'b0}}, target_q[0]};
        iob.iob_wstrb  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      hart_q     <= '0;
      target_q   <= '0;
      hi1_q      <= '0;
      lo_q       <= '0;
      retry_q    <= '0;
      rd_wait_q  <= 1'b0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else if (cke_i) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            op_q      <= cmd_op_i;
            hart_q    <= cmd_hart_i;
            target_q  <= cmd_data_i;
            retry_q   <= '0;
            rd_wait_q <= 1'b0;
            if (!hart_ok) begin
              rsp_data_o <= '0;
              rsp_err_o  <= 1'b1;
              state_q    <= ST_RESP;
            end else begin
              case (cmd_op_i)
                OP_SET_CMP_ABS: state_q <= ST_WR_LO1;
                OP_SET_MSIP:    state_q <= ST_WR_MSIP;
                default:        state_q <= ST_RD_HI1;
              endcase
            end
          end
        end
        ST_RD_HI1: begin
          if (rd_accept) rd_wait_q <= 1'b1;
          if (rd_done) begin
            rd_wait_q <= 1'b0;
            hi1_q     <= iob.iob_rdata;
            state_q   <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (rd_accept) rd_wait_q <= 1'b1;
          if (rd_done) begin
            rd_wait_q <= 1'b0;
            lo_q      <= iob.iob_rdata;
            state_q   <= ST_RD_HI2;
          end
        end
        ST_RD_HI2: begin
          if (rd_accept) rd_wait_q <= 1'b1;
          if (rd_done) begin
            rd_wait_q <= 1'b0;
            if (iob.iob_rdata == hi1_q) begin
              if (op_q == OP_RD_TIME) begin
                rsp_data_o <= {hi1_q, lo_q};
                rsp_err_o  <= 1'b0;
                state_q    <= ST_RESP;
              end else begin
                state_q <= ST_ADD;
              end
            end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
              rsp_data_o <= {iob.iob_rdata, lo_q};
              rsp_err_o  <= 1'b1;
              state_q    <= ST_RESP;
            end else begin
              // hi rolled over between reads: newest hi becomes the reference
              retry_q <= retry_q + 1'b1;
              hi1_q   <= iob.iob_rdata;
              state_q <= ST_RD_LO;
            end
          end
        end
        ST_ADD: begin
          target_q <= {hi1_q, lo_q} + target_q;
          state_q  <= ST_WR_LO1;
        end
        ST_WR_LO1: if (iob.iob_ready) state_q <= ST_WR_HI;
        ST_WR_HI:  if (iob.iob_ready) state_q <= ST_WR_LO2;
        ST_WR_LO2: begin
          if (iob.iob_ready) begin
            rsp_data_o <= target_q;
            rsp_err_o  <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_WR_MSIP: begin
          if (iob.iob_ready) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_clint_timer_agent.sv
// Bench for iob_clint_timer_agent: CLINT subordinate model with configurable
// stalls and scripted mtime hi/lo read values, a command-level model that
// produces the expected bus transactions and response, and one compare process.
module tb_iob_clint_timer_agent;
  localparam int N_CORES   = 3;
  localparam int MAX_RETRY = 3;
  localparam int HART_W    = 2;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              arst, cke;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [HART_W-1:0] cmd_hart;
  logic [63:0]       cmd_data;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [63:0]       rsp_data;

  iob_clint_timer_agent_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_clint_timer_agent #(
    .N_CORES(N_CORES), .ADDR_W(16), .DATA_W(32),
    .BASE_ADDR(16'h0000), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_hart_i(cmd_hart), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .iob(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected traffic and response
  txn_t        exp_q[$];
  logic        exp_rsp_on = 1'b0;
  logic [63:0] exp_rsp_data = '0;
  logic        exp_rsp_err = 1'b0;

  // CLINT model state
  logic [63:0] mtime_static = '0;
  logic [31:0] hi_vals[$];
  logic [31:0] lo_vals[$];
  int          hi_idx = 0, lo_idx = 0;
  logic [63:0] mtimecmp [N_CORES];
  logic        msip [N_CORES];
  int          stall_cfg = 0, stall_left = 0, n_writes = 0;
  bit          junk_rv = 1'b0;

  logic [63:0] got_data;
  logic        got_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hi_at(input int i);
    if (i < hi_vals.size()) return hi_vals[i];
    return mtime_static[63:32];
  endfunction

  function automatic logic [31:0] lo_at(input int i);
    if (i < lo_vals.size()) return lo_vals[i];
    return mtime_static[31:0];
  endfunction

  // ---------------- CLINT subordinate ----------------
  initial begin
    logic        acc, a_we;
    logic [15:0] a_addr;
    logic [31:0] a_wd;
    bus.iob_ready  = 1'b1;
    bus.iob_rvalid = 1'b0;
    bus.iob_rdata  = '0;
    forever begin
      @(negedge clk);
      acc    = bus.iob_avalid && bus.iob_ready && cke && !arst;
      a_we   = (bus.iob_wstrb != 4'h0);
      a_addr = bus.iob_addr;
      a_wd   = bus.iob_wdata;
      if (bus.iob_avalid && !bus.iob_ready && stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
      bus.iob_rvalid = 1'b0;
      if (acc) begin
        stall_left = stall_cfg;
        if (a_we) begin
          n_writes++;
          for (int h = 0; h < N_CORES; h++) begin
            if (a_addr == 16'(4 * h))              msip[h] = a_wd[0];
            if (a_addr == 16'(32'h4000 + 8 * h))   mtimecmp[h][31:0]  = a_wd;
            if (a_addr == 16'(32'h4004 + 8 * h))   mtimecmp[h][63:32] = a_wd;
          end
        end else begin
          bus.iob_rvalid = 1'b1;
          if (a_addr == 16'hBFFC) begin
            bus.iob_rdata = hi_at(hi_idx); hi_idx++;
          end else if (a_addr == 16'hBFF8) begin
            bus.iob_rdata = lo_at(lo_idx); lo_idx++;
          end else begin
            bus.iob_rdata = '0;
          end
        end
      end else if (junk_rv && bus.iob_avalid && bus.iob_wstrb == 4'h0) begin
        // rvalid asserted in the cycle a read is being accepted
        bus.iob_rvalid = 1'b1;
        bus.iob_rdata  = 32'hDEAD_BEEF;
      end
      bus.iob_ready = (stall_left == 0);
    end
  end

  // ---------------- command-level model ----------------
  task automatic push_txn(input logic we, input logic [15:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic push_cmp(input int hart, input logic [63:0] tgt);
    push_txn(1'b1, 16'(32'h4000 + 8 * hart), 32'hFFFF_FFFF);
    push_txn(1'b1, 16'(32'h4004 + 8 * hart), tgt[63:32]);
    push_txn(1'b1, 16'(32'h4000 + 8 * hart), tgt[31:0]);
  endtask

  task automatic model_cmd(input logic [1:0] op, input int hart, input logic [63:0] d);
    logic [31:0] h1, h2, lo;
    bit          ok;
    exp_rsp_on = 1'b1;
    exp_rsp_err = 1'b0;
    exp_rsp_data = '0;
    if (hart >= N_CORES) begin
      exp_rsp_err = 1'b1;
    end else if (op == 2'd3) begin
      push_txn(1'b1, 16'(4 * hart), {31'b0, d[0]});
    end else if (op == 2'd1) begin
      push_cmp(hart, d);
      exp_rsp_data = d;
    end else begin
      ok = 1'b0;
      h1 = hi_at(0);
      h2 = h1;
      lo = '0;
      push_txn(1'b0, 16'hBFFC, '0);
      for (int p = 0; p <= MAX_RETRY && !ok; p++) begin
        lo = lo_at(p);
        h2 = hi_at(p + 1);
        push_txn(1'b0, 16'hBFF8, '0);
        push_txn(1'b0, 16'hBFFC, '0);
        if (h2 == h1) ok = 1'b1;
        else h1 = h2;
      end
      if (!ok) begin
        exp_rsp_err  = 1'b1;
        exp_rsp_data = {h2, lo};
      end else if (op == 2'd0) begin
        exp_rsp_data = {h1, lo};
      end else begin
        exp_rsp_data = {h1, lo} + d;
        push_cmp(hart, exp_rsp_data);
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!arst) begin
        if (bus.iob_avalid) begin
          if (exp_q.size() == 0) begin
            chk("no_access_expected", {63'b0, bus.iob_avalid}, 64'd0);
          end else begin
            chk("bus_addr", {48'b0, bus.iob_addr}, {48'b0, exp_q[0].addr});
            chk("bus_wstrb", {60'b0, bus.iob_wstrb}, exp_q[0].we ? 64'hF : 64'h0);
            if (exp_q[0].we) chk("bus_wdata", {32'b0, bus.iob_wdata}, {32'b0, exp_q[0].wdata});
            if (bus.iob_ready && cke) void'(exp_q.pop_front());
          end
        end
        if (rsp_valid) begin
          if (!exp_rsp_on) begin
            chk("no_rsp_expected", {63'b0, rsp_valid}, 64'd0);
          end else begin
            chk("rsp_data", rsp_data, exp_rsp_data);
            chk("rsp_err", {63'b0, rsp_err}, {63'b0, exp_rsp_err});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input int hart, input logic [63:0] d);
    int guard = 0;
    model_cmd(op, hart, d);
    hi_idx = 0;
    lo_idx = 0;
    cmd_op = op;
    cmd_hart = hart[HART_W-1:0];
    cmd_data = d;
    cmd_valid = 1'b1;
    do begin @(negedge clk); guard++; end while (!cmd_ready && guard < 50);
    chk("cmd_accept_timeout", {63'b0, cmd_ready}, 64'd1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int hart, input logic [63:0] d,
                        input int exp_lat, input bit freeze);
    int t_fire, guard;
    issue(op, hart, d);
    t_fire = cyc;
    @(posedge clk); #1 cmd_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 400);
    chk("rsp_timeout", {63'b0, rsp_valid}, 64'd1);
    if (exp_lat > 0) chk("latency", 64'(cyc - t_fire), 64'(exp_lat));
    got_data = rsp_data;
    got_err  = rsp_err;
    if (freeze) begin
      @(posedge clk); #1 cke = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rsp_ready = 1'b0; cke = 1'b1;
      @(negedge clk);
      chk("cke_freeze_rsp_held", {63'b0, rsp_valid}, 64'd1);
      chk("cke_freeze_data_held", rsp_data, got_data);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    chk("ready_after_rsp", {63'b0, cmd_ready}, 64'd1);
    chk("rsp_cleared", {63'b0, rsp_valid}, 64'd0);
    chk("pending_txns", 64'(exp_q.size()), 64'd0);
    exp_rsp_on = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int guard;
    bit reached;
    arst = 1'b1; cke = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_hart = '0; cmd_data = '0; rsp_ready = 1'b0;
    for (int h = 0; h < N_CORES; h++) begin
      mtimecmp[h] = 64'hAAAA_AAAA_AAAA_AAAA;
      msip[h] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_avalid", {63'b0, bus.iob_avalid}, 64'd0);
    chk("rst_addr_wdata_wstrb", {12'b0, bus.iob_addr, bus.iob_wdata, bus.iob_wstrb}, 64'd0);
    @(posedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;

    // static mtime, zero-wait subordinate
    mtime_static = 64'h0000_0001_FFFF_FFF0;
    do_cmd(2'd0, 0, 64'd0, 7, 1'b0);
    chk("rd_static_value", got_data, 64'h0000_0001_FFFF_FFF0);
    chk("rd_static_err", {63'b0, got_err}, 64'd0);
    chk("rd_static_hi_reads", 64'(hi_idx), 64'd2);
    chk("rd_static_lo_reads", 64'(lo_idx), 64'd1);

    // hi rolls 1 -> 2 once, stray rvalid during acceptance cycles
    junk_rv = 1'b1;
    hi_vals = '{32'd1, 32'd2, 32'd2};
    lo_vals = '{32'hFFFF_0000, 32'd5};
    do_cmd(2'd0, 0, 64'd0, 0, 1'b0);
    chk("rd_retry_value", got_data, 64'h0000_0002_0000_0005);
    chk("rd_retry_err", {63'b0, got_err}, 64'd0);
    junk_rv = 1'b0;

    // hi changes on every pass: retry exhaustion
    hi_vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    lo_vals = '{32'h10, 32'h11, 32'h12, 32'h13};
    do_cmd(2'd0, 0, 64'd0, 0, 1'b0);
    chk("rd_exhaust_err", {63'b0, got_err}, 64'd1);
    chk("rd_exhaust_data", got_data, 64'h0000_0005_0000_0013);
    chk("rd_exhaust_lo_reads", 64'(lo_idx), 64'd4);
    hi_vals.delete();
    lo_vals.delete();

    // relative compare with 64-bit wrap, hart 1
    mtime_static = 64'hFFFF_FFFF_FFFF_FFFE;
    do_cmd(2'd2, 1, 64'd4, 0, 1'b0);
    chk("rel_rsp_value", got_data, 64'd2);
    chk("rel_mtimecmp1", mtimecmp[1], 64'd2);

    // absolute compare with 3-cycle ready stall per access
    stall_cfg = 3; stall_left = 3;
    n_writes = 0;
    do_cmd(2'd1, 0, 64'h0000_0010_0000_0020, 0, 1'b0);
    chk("abs_stall_writes", 64'(n_writes), 64'd3);
    chk("abs_mtimecmp0", mtimecmp[0], 64'h0000_0010_0000_0020);
    stall_cfg = 0; stall_left = 0;
    @(posedge clk); #1;

    // absolute compare, zero wait, latency and cke freeze in RESP
    do_cmd(2'd1, 2, 64'h1234_5678_9ABC_DEF0, 4, 1'b1);
    chk("abs_mtimecmp2", mtimecmp[2], 64'h1234_5678_9ABC_DEF0);

    // msip to a hart that does not exist, then hart 0
    do_cmd(2'd3, N_CORES, 64'd1, 0, 1'b0);
    chk("msip_bad_hart_err", {63'b0, got_err}, 64'd1);
    chk("msip_bad_hart_data", got_data, 64'd0);
    do_cmd(2'd3, 0, 64'd1, 0, 1'b0);
    chk("msip_ok_err", {63'b0, got_err}, 64'd0);
    chk("msip0_set", {63'b0, msip[0]}, 64'd1);

    // async reset while WR_HI is stalled
    stall_cfg = 3; stall_left = 3;
    issue(2'd1, 1, 64'h0000_0077_0000_0088);
    @(posedge clk); #1 cmd_valid = 1'b0;
    reached = 1'b0;
    guard = 0;
    while (!reached && guard < 50) begin
      @(negedge clk);
      guard++;
      if (bus.iob_avalid && bus.iob_addr == 16'h400C) reached = 1'b1;
    end
    chk("wr_hi_reached", {63'b0, reached}, 64'd1);
    @(posedge clk); #1;
    arst = 1'b1;
    exp_q.delete();
    exp_rsp_on = 1'b0;
    stall_cfg = 0; stall_left = 0;
    #2;
    chk("arst_avalid_dropped", {63'b0, bus.iob_avalid}, 64'd0);
    @(posedge clk); #1 arst = 1'b0;
    @(negedge clk);
    chk("arst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    chk("arst_no_rsp", {63'b0, rsp_valid}, 64'd0);
    chk("arst_partial_cmp", mtimecmp[1], 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;

    // normal read after the reset
    mtime_static = 64'hCAFE_0000_1234_5678;
    do_cmd(2'd0, 0, 64'd0, 7, 1'b0);
    chk("rd_after_arst", got_data, 64'hCAFE_0000_1234_5678);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
